// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;
  localparam int   CNT_W    = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on contention the requester that
// was not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else if (req1) begin
      gnt_id = REQ_DBG;
    end else begin
      gnt_id = REQ_CORE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory_access_ctrl port between the core and a debug/DMA master,
// one transaction in flight. Define MEM_ARB_STATS_EN to add grant/wait counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int BYTES_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r0_mem_ena,
  input  logic               w0_mem_ena,
  input  logic [ADDR_W-1:0]  rw0_mem_addr,
  input  logic [BYTES_W-1:0] rw0_mem_bytes,
  input  logic [DATA_W-1:0]  w0_mem_data,
  output logic               mem_data_ready0,
  output logic [DATA_W-1:0]  mem_data0,
  input  logic               r1_mem_ena,
  input  logic               w1_mem_ena,
  input  logic [ADDR_W-1:0]  rw1_mem_addr,
  input  logic [BYTES_W-1:0] rw1_mem_bytes,
  input  logic [DATA_W-1:0]  w1_mem_data,
  output logic               mem_data_ready1,
  output logic [DATA_W-1:0]  mem_data1,
  output logic               r_mem_ena,
  output logic               w_mem_ena,
  output logic [ADDR_W-1:0]  rw_mem_addr,
  output logic [BYTES_W-1:0] rw_mem_bytes,
  output logic [DATA_W-1:0]  w_mem_data,
  input  logic               mem_data_ready,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               grant_id
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1,
  output logic [CNT_W-1:0]   wait_cnt1
`endif
);

  arb_state_e         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_id_q, grant_id_d;
  logic               r_ena_q, r_ena_d;
  logic               w_ena_q, w_ena_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BYTES_W-1:0] bytes_q, bytes_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               rdy0_q, rdy0_d;
  logic               rdy1_q, rdy1_d;
  logic [DATA_W-1:0]  rdata0_q, rdata0_d;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d;

  logic req0, req1;
  logic gnt_valid, gnt_id;
  logic               win_r, win_w;
  logic [ADDR_W-1:0]  win_addr;
  logic [BYTES_W-1:0] win_bytes;
  logic [DATA_W-1:0]  win_wdata;

  assign req0 = r0_mem_ena | w0_mem_ena;
  assign req1 = r1_mem_ena | w1_mem_ena;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    if (gnt_id == REQ_DBG) begin
      win_r     = r1_mem_ena;
      win_w     = w1_mem_ena;
      win_addr  = rw1_mem_addr;
      win_bytes = rw1_mem_bytes;
      win_wdata = w1_mem_data;
    end else begin
      win_r     = r0_mem_ena;
      win_w     = w0_mem_ena;
      win_addr  = rw0_mem_addr;
      win_bytes = rw0_mem_bytes;
      win_wdata = w0_mem_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    r_ena_d      = r_ena_q;
    w_ena_d      = w_ena_q;
    addr_d       = addr_q;
    bytes_d      = bytes_q;
    wdata_d      = wdata_q;
    rdy0_d       = 1'b0;
    rdy1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d      = BUSY;
          grant_id_d   = gnt_id;
          last_grant_d = gnt_id;
          // A requester asserting both enables is served as a write.
          w_ena_d      = win_w;
          r_ena_d      = win_r & ~win_w;
          addr_d       = win_addr;
          bytes_d      = win_bytes;
          wdata_d      = win_wdata;
        end
      end
      BUSY: begin
        if (mem_data_ready) begin
          state_d = DRAIN;
          r_ena_d = 1'b0;
          w_ena_d = 1'b0;
          if (grant_id_q == REQ_DBG) begin
            rdy1_d   = 1'b1;
            rdata1_d = mem_data;
          end else begin
            rdy0_d   = 1'b1;
            rdata0_d = mem_data;
          end
        end
      end
      // Skip one arbitration so the served requester can drop its request.
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_DBG;
      grant_id_q   <= REQ_CORE;
      r_ena_q      <= 1'b0;
      w_ena_q      <= 1'b0;
      addr_q       <= '0;
      bytes_q      <= '0;
      wdata_q      <= '0;
      rdy0_q       <= 1'b0;
      rdy1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      r_ena_q      <= r_ena_d;
      w_ena_q      <= w_ena_d;
      addr_q       <= addr_d;
      bytes_q      <= bytes_d;
      wdata_q      <= wdata_d;
      rdy0_q       <= rdy0_d;
      rdy1_q       <= rdy1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign r_mem_ena       = r_ena_q;
  assign w_mem_ena       = w_ena_q;
  assign rw_mem_addr     = addr_q;
  assign rw_mem_bytes    = bytes_q;
  assign w_mem_data      = wdata_q;
  assign mem_data_ready0 = rdy0_q;
  assign mem_data_ready1 = rdy1_q;
  assign mem_data0       = rdata0_q;
  assign mem_data1       = rdata1_q;
  assign grant_id        = grant_id_q;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;
  logic [CNT_W-1:0] wait_cnt1_q, wait_cnt1_d;
  logic             owned1;

  // Requester 1 is not waiting on the cycle it wins or while it is being served.
  assign owned1 = ((state_q == IDLE) && gnt_valid && (gnt_id == REQ_DBG)) ||
                  ((state_q == BUSY) && (grant_id_q == REQ_DBG));

  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    wait_cnt1_d  = wait_cnt1_q;
    if ((state_q == IDLE) && gnt_valid) begin
      if (gnt_id == REQ_DBG) grant_cnt1_d = sat_inc(grant_cnt1_q);
      else                   grant_cnt0_d = sat_inc(grant_cnt0_q);
    end
    if (req1 && !owned1) wait_cnt1_d = sat_inc(wait_cnt1_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      wait_cnt1_q  <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      wait_cnt1_q  <= wait_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign wait_cnt1  = wait_cnt1_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner
// sequences and randomized rounds against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_r [2];
  logic        req_w [2];
  logic [63:0] req_a [2];
  logic [2:0]  req_b [2];
  logic [63:0] req_d [2];
  logic        mem_data_ready;
  logic [63:0] mem_data;

  logic        mem_data_ready0, mem_data_ready1;
  logic [63:0] mem_data0, mem_data1;
  logic        r_mem_ena, w_mem_ena;
  logic [63:0] rw_mem_addr;
  logic [2:0]  rw_mem_bytes;
  logic [63:0] w_mem_data;
  logic        grant_id;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1, wait_cnt1;
`endif

  mem_port_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .r0_mem_ena      (req_r[0]),
    .w0_mem_ena      (req_w[0]),
    .rw0_mem_addr    (req_a[0]),
    .rw0_mem_bytes   (req_b[0]),
    .w0_mem_data     (req_d[0]),
    .mem_data_ready0 (mem_data_ready0),
    .mem_data0       (mem_data0),
    .r1_mem_ena      (req_r[1]),
    .w1_mem_ena      (req_w[1]),
    .rw1_mem_addr    (req_a[1]),
    .rw1_mem_bytes   (req_b[1]),
    .w1_mem_data     (req_d[1]),
    .mem_data_ready1 (mem_data_ready1),
    .mem_data1       (mem_data1),
    .r_mem_ena       (r_mem_ena),
    .w_mem_ena       (w_mem_ena),
    .rw_mem_addr     (rw_mem_addr),
    .rw_mem_bytes    (rw_mem_bytes),
    .w_mem_data      (w_mem_data),
    .mem_data_ready  (mem_data_ready),
    .mem_data        (mem_data),
    .grant_id        (grant_id)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_cnt0      (grant_cnt0),
    .grant_cnt1      (grant_cnt1),
    .wait_cnt1       (wait_cnt1)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: who was served last, last read data per requester,
  // grant counts and cycles requester 1 spent waiting.
  int          last_model;
  logic [63:0] last_rdata [2];
  int          gcnt_model [2];
  int          wait_model;
  bit          track;
  bit          serving1;

  always @(posedge clk)
    if (track && (req_r[1] | req_w[1]) && !serving1) wait_model++;

  typedef struct {
    logic        r0, w0, r1, w1;
    logic [63:0] a0, d0, a1, d1;
    int          exp_gid;
    logic        exp_r, exp_w;
    logic [63:0] rd;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int id);
    return (id == 1) ? mem_data_ready1 : mem_data_ready0;
  endfunction

  function automatic logic [63:0] get_data(input int id);
    return (id == 1) ? mem_data1 : mem_data0;
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_r_ena"}, 64'(r_mem_ena), 64'd0);
    chk({name, "_w_ena"}, 64'(w_mem_ena), 64'd0);
    chk({name, "_addr"},  rw_mem_addr, 64'd0);
    chk({name, "_bytes"}, 64'(rw_mem_bytes), 64'd0);
    chk({name, "_wdata"}, w_mem_data, 64'd0);
    chk({name, "_rdy01"}, 64'({mem_data_ready0, mem_data_ready1}), 64'd0);
    chk({name, "_data0"}, mem_data0, 64'd0);
    chk({name, "_data1"}, mem_data1, 64'd0);
    chk({name, "_gid"},   64'(grant_id), 64'd0);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      req_r[i] = 1'b0;
      req_w[i] = 1'b0;
    end
  endtask

  // Called one step after the grant edge; completes the transaction of `id`.
  task automatic serve(input int id, input logic [63:0] rd);
    int lat;
    int oth;
    oth = 1 - id;
    chk("grant_id", 64'(grant_id), 64'(id));
    chk("w_ena",    64'(w_mem_ena), 64'(req_w[id]));
    chk("r_ena",    64'(r_mem_ena), 64'(req_r[id] & ~req_w[id]));
    chk("addr",     rw_mem_addr, req_a[id]);
    chk("bytes",    64'(rw_mem_bytes), 64'(req_b[id]));
    chk("wdata",    w_mem_data, req_d[id]);
    lat = $urandom_range(0, 3);
    repeat (lat) tick();
    chk("hold_ena",  64'(r_mem_ena | w_mem_ena), 64'd1);
    chk("hold_addr", rw_mem_addr, req_a[id]);
    mem_data       = rd;
    mem_data_ready = 1'b1;
    tick();
    mem_data_ready = 1'b0;
    mem_data       = '0;
    chk("rdy_pulse",  64'(get_rdy(id)), 64'd1);
    chk("rdy_other",  64'(get_rdy(oth)), 64'd0);
    chk("rdata",      get_data(id), rd);
    chk("rdata_hold", get_data(oth), last_rdata[oth]);
    chk("ena_drop",   64'(r_mem_ena | w_mem_ena), 64'd0);
    last_rdata[id] = rd;
    gcnt_model[id]++;
    req_r[id] = 1'b0;
    req_w[id] = 1'b0;
    serving1  = 1'b0;
  endtask

  task automatic round(input logic [1:0] who);
    int win;
    int lose;
    logic [1:0] rw;
    for (int i = 0; i < 2; i++) begin
      if (who[i]) begin
        rw       = 2'($urandom_range(1, 3));
        req_r[i] = rw[0];
        req_w[i] = rw[1];
        req_a[i] = {$urandom, $urandom};
        req_b[i] = 3'($urandom_range(0, 7));
        req_d[i] = {$urandom, $urandom};
      end
    end
    if (who == 2'b11) win = 1 - last_model;
    else              win = who[1] ? 1 : 0;
    serving1 = (win == 1);
    tick();
    serve(win, {$urandom, $urandom});
    last_model = win;
    if (who == 2'b11) begin
      lose = 1 - win;
      tick();
      chk("rr_gap_ena",  64'(r_mem_ena | w_mem_ena), 64'd0);
      chk("pulse_width", 64'(get_rdy(win)), 64'd0);
      serving1 = (lose == 1);
      tick();
      serve(lose, {$urandom, $urandom});
      last_model = lose;
    end
    tick();
  endtask

  initial begin
    int first;
    int id;
    logic [63:0] rd;
    logic [63:0] a_saved;

    track      = 1'b0;
    serving1   = 1'b0;
    wait_model = 0;
    last_model = 1;
    for (int i = 0; i < 2; i++) begin
      last_rdata[i] = '0;
      gcnt_model[i] = 0;
      req_a[i]      = '0;
      req_b[i]      = '0;
      req_d[i]      = '0;
    end
    clear_reqs();
    mem_data_ready = 1'b0;
    mem_data       = '0;

    //             r0    w0    r1    w1    a0                    d0     a1                    d1                    gid r     w     rd
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 64'h0, 64'h0, 0, 1'b1, 1'b0, 64'h1122_3344_5566_7788};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h0000_0000_8000_0010, 64'h0, 64'h0000_0000_9000_0000, 64'h0, 1, 1'b1, 1'b0, 64'hA5A5_0000_0000_0001};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0020, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_9000_0008, 64'h0, 0, 1'b0, 1'b1, 64'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0000_0000_9000_0010, 64'h0000_0000_DEAD_BEEF, 1, 1'b0, 1'b1, 64'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0000_0000_9000_0018, 64'hCAFE_F00D_0000_0002, 1, 1'b0, 1'b1, 64'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0040, 64'h0, 64'h0000_0000_9000_0020, 64'h5555_AAAA_5555_AAAA, 0, 1'b1, 1'b0, 64'h8877_6655_4433_2211};

    rst = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // Vector table, starting from the post-reset round-robin state.
    for (int v = 0; v < 6; v++) begin
      req_r[0] = tbl[v].r0;  req_w[0] = tbl[v].w0;
      req_a[0] = tbl[v].a0;  req_d[0] = tbl[v].d0;  req_b[0] = 3'd3;
      req_r[1] = tbl[v].r1;  req_w[1] = tbl[v].w1;
      req_a[1] = tbl[v].a1;  req_d[1] = tbl[v].d1;  req_b[1] = 3'd5;
      tick();
      chk("tbl_gid",   64'(grant_id), 64'(tbl[v].exp_gid));
      chk("tbl_r_ena", 64'(r_mem_ena), 64'(tbl[v].exp_r));
      chk("tbl_w_ena", 64'(w_mem_ena), 64'(tbl[v].exp_w));
      serve(tbl[v].exp_gid, tbl[v].rd);
      last_model = tbl[v].exp_gid;
      clear_reqs();
      tick();
    end

    // Downstream ready while idle must be ignored.
    mem_data       = 64'hFFFF_0000_FFFF_0000;
    mem_data_ready = 1'b1;
    tick();
    mem_data_ready = 1'b0;
    chk("idle_rdy0",  64'(mem_data_ready0), 64'd0);
    chk("idle_rdy1",  64'(mem_data_ready1), 64'd0);
    chk("idle_data0", mem_data0, last_rdata[0]);
    chk("idle_ena",   64'(r_mem_ena | w_mem_ena), 64'd0);
    tick();

    // Request withdrawn and fields changed while busy: ignored, still completes.
    a_saved  = 64'h0000_1000_0000_0040;
    req_r[0] = 1'b1;
    req_a[0] = a_saved;
    req_b[0] = 3'd2;
    tick();
    chk("wd_gid",   64'(grant_id), 64'd0);
    chk("wd_r_ena", 64'(r_mem_ena), 64'd1);
    req_r[0] = 1'b0;
    req_w[0] = 1'b1;
    req_a[0] = ~a_saved;
    tick();
    tick();
    chk("wd_hold_addr", rw_mem_addr, a_saved);
    chk("wd_hold_rw",   64'({r_mem_ena, w_mem_ena}), 64'b10);
    rd             = 64'h0BAD_F00D_1234_5678;
    mem_data       = rd;
    mem_data_ready = 1'b1;
    req_w[0]       = 1'b0;
    tick();
    mem_data_ready = 1'b0;
    chk("wd_rdy0",  64'(mem_data_ready0), 64'd1);
    chk("wd_data0", mem_data0, rd);
    last_rdata[0] = rd;
    last_model    = 0;
    tick();
    tick();

    // Continuous contention: both hold requests, grants must alternate.
    first    = 1 - last_model;
    req_r[0] = 1'b1;  req_a[0] = {$urandom, $urandom};  req_b[0] = 3'd7;
    req_w[1] = 1'b1;  req_a[1] = {$urandom, $urandom};  req_d[1] = {$urandom, $urandom};
    tick();
    for (int k = 0; k < 9; k++) begin
      id = first ^ (k & 1);
      chk("contend_gid",  64'(grant_id), 64'(id));
      chk("contend_addr", rw_mem_addr, req_a[id]);
      if (k == 8) clear_reqs();
      tick();
      rd             = {$urandom, $urandom};
      mem_data       = rd;
      mem_data_ready = 1'b1;
      tick();
      mem_data_ready = 1'b0;
      chk("contend_rdy",  64'(get_rdy(id)), 64'd1);
      chk("contend_data", get_data(id), rd);
      last_rdata[id] = rd;
      last_model     = id;
      if (k < 8) begin
        req_a[id] = {$urandom, $urandom};
        tick();
        chk("contend_gap", 64'(r_mem_ena | w_mem_ena), 64'd0);
        tick();
      end else begin
        tick();
        tick();
      end
    end

    // Asynchronous reset in the middle of a write.
    req_w[1] = 1'b1;
    req_a[1] = 64'h0000_0000_A000_0000;
    req_d[1] = 64'h1234_5678_9ABC_DEF0;
    tick();
    chk("midrst_w_ena", 64'(w_mem_ena), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    clear_reqs();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    last_model = 1;
    for (int i = 0; i < 2; i++) begin
      last_rdata[i] = '0;
      gcnt_model[i] = 0;
    end
    wait_model = 0;
    serving1   = 1'b0;
    track      = 1'b1;
    round(2'b10);

    // Randomized rounds against the model.
    for (int n = 0; n < 40; n++) round(2'($urandom_range(1, 3)));

`ifdef MEM_ARB_STATS_EN
    chk("stat_grant0", 64'(grant_cnt0), 64'(gcnt_model[0]));
    chk("stat_grant1", 64'(grant_cnt1), 64'(gcnt_model[1]));
    chk("stat_wait1",  64'(wait_cnt1),  64'(wait_model));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
